// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial byte link: byte width, sync pattern and
// receiver state encoding.
package serial_link_pkg;

  localparam int unsigned BYTE_W = 8;

  // Alignment pattern, also used by the serializer-side framer.
  localparam logic [BYTE_W-1:0] SYNC_WORD_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    StIdle,
    StHunt,
    StLocked
  } link_state_e;

endpackage

// File: rtl/serial_byte_receiver_if.sv
// Receiver-side bundle: control and serial inputs, recovered byte and status.
interface serial_byte_receiver_if;
  import serial_link_pkg::*;

  logic              en;
  logic              sclk;
  logic              sdata;
  logic [BYTE_W-1:0] data;
  logic              valid;
  logic              locked;
  logic              lost;

  modport master (
    output en,
    output sclk,
    output sdata,
    input  data,
    input  valid,
    input  locked,
    input  lost
  );

  modport slave (
    input  en,
    input  sclk,
    input  sdata,
    output data,
    output valid,
    output locked,
    output lost
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with a third flop for rising-edge detection.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/serial_byte_receiver.sv
// Oversampling serial byte receiver: hunts for the sync byte, then emits each
// following 8-bit group as a one-cycle strobe; drops lock on bit-clock loss.
module serial_byte_receiver
  import serial_link_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int unsigned       TIMEOUT   = 64
) (
  input logic                   clk,
  input logic                   rst,
  serial_byte_receiver_if.slave rx_io
);

  localparam int unsigned          TmoW   = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0]      TmoMax = TmoW'(TIMEOUT);
  localparam int unsigned          CntW   = $clog2(BYTE_W);
  localparam logic [CntW-1:0]      CntLast = CntW'(BYTE_W - 1);

  logic sclk_rise;
  logic sclk_lvl_unused;
  logic sdata_lvl;
  logic unused_sdata_rise;

  sync_edge_detect u_sclk_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (rx_io.sclk),
    .level_o (sclk_lvl_unused),
    .rise_o  (sclk_rise)
  );

  sync_edge_detect u_sdata_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (rx_io.sdata),
    .level_o (sdata_lvl),
    .rise_o  (unused_sdata_rise)
  );

  link_state_e       state_q, state_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              valid_q, valid_d;
  logic              lost_q, lost_d;
  logic [BYTE_W-1:0] shift_next;
  logic [TmoW-1:0]   tmo_inc;

  assign shift_next = {shift_q[BYTE_W-2:0], sdata_lvl};
  assign tmo_inc    = (tmo_q == TmoMax) ? tmo_q : tmo_q + TmoW'(1);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    valid_d   = 1'b0;
    lost_d    = 1'b0;

    // A low enable overrides everything, including a completing byte.
    if (!rx_io.en) begin
      state_d   = StIdle;
      shift_d   = '0;
      bit_cnt_d = '0;
      tmo_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StHunt;
        end

        StHunt: begin
          if (sclk_rise) begin
            shift_d = shift_next;
            if (shift_next == SYNC_WORD) begin
              state_d   = StLocked;
              bit_cnt_d = '0;
              tmo_d     = '0;
            end
          end
        end

        StLocked: begin
          if (sclk_rise) begin
            shift_d = shift_next;
            tmo_d   = '0;
            if (bit_cnt_q == CntLast) begin
              data_d    = shift_next;
              valid_d   = 1'b1;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CntW'(1);
            end
          end else if (tmo_inc == TmoMax) begin
            state_d   = StHunt;
            lost_d    = 1'b1;
            shift_d   = '0;
            bit_cnt_d = '0;
            tmo_d     = '0;
          end else begin
            tmo_d = tmo_inc;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      data_q    <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      valid_q   <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      valid_q   <= valid_d;
      lost_q    <= lost_d;
    end
  end

  assign rx_io.data   = data_q;
  assign rx_io.valid  = valid_q;
  assign rx_io.locked = (state_q == StLocked);
  assign rx_io.lost   = lost_q;

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Randomized bench for serial_byte_receiver against a bit-stream reference model.
module tb_serial_byte_receiver;

  localparam int unsigned TIMEOUT = 64;
  localparam logic [7:0]  SYNC    = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_byte_receiver_if rx_if ();

  serial_byte_receiver #(
    .SYNC_WORD (SYNC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_io (rx_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rise_cyc = 0;
  bit started = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference model: bits are taken two clocks after sclk is seen high; the
  // receiver is described as hunt/locked modes over the recovered bit stream.
  int         mode;  // 0 idle, 1 hunting, 2 locked
  logic [7:0] win;
  int         nbits;
  int         idle;
  logic [7:0] m_data;
  bit         m_valid, m_lost;
  logic       sh [3];
  logic       dh [2];
  logic [7:0] got_q [$];
  int         lost_cnt = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mode = 0; win = '0; nbits = 0; idle = 0;
        m_data = '0; m_valid = 1'b0; m_lost = 1'b0;
        sh[0] = 0; sh[1] = 0; sh[2] = 0; dh[0] = 0; dh[1] = 0;
      end else begin
        bit   rise;
        logic b;
        rise = sh[1] && !sh[2];
        b    = dh[1];
        m_valid = 1'b0;
        m_lost  = 1'b0;
        if (!rx_if.en) begin
          mode = 0; win = '0; nbits = 0; idle = 0;
        end else if (mode == 0) begin
          mode = 1;
        end else if (mode == 1) begin
          if (rise) begin
            win = {win[6:0], b};
            if (win == SYNC) begin
              mode = 2; nbits = 0; idle = 0;
            end
          end
        end else begin
          if (rise) begin
            win   = {win[6:0], b};
            idle  = 0;
            nbits = nbits + 1;
            if (nbits == 8) begin
              m_data  = win;
              m_valid = 1'b1;
              nbits   = 0;
              got_q.push_back(win);
            end
          end else begin
            idle = idle + 1;
            if (idle >= TIMEOUT) begin
              mode = 1; m_lost = 1'b1; nbits = 0; idle = 0; win = '0;
              lost_cnt++;
            end
          end
        end
        sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = rx_if.sclk;
        dh[1] = dh[0]; dh[0] = rx_if.sdata;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started && rst === 1'b0) begin
        chk("data", int'(rx_if.data), int'(m_data));
        chk("valid", int'(rx_if.valid), int'(m_valid));
        chk("locked", int'(rx_if.locked), (mode == 2) ? 1 : 0);
        chk("lost", int'(rx_if.lost), int'(m_lost));
        if (rx_if.valid) chk("valid_latency", cyc - last_rise_cyc, 3);
        if (rx_if.lost) chk("lost_latency", cyc - last_rise_cyc, TIMEOUT + 3);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int half, input bit drop_en);
    rx_if.sclk  = 1'b0;
    rx_if.sdata = b;
    tick(half);
    rx_if.sclk    = 1'b1;
    last_rise_cyc = cyc;
    if (drop_en) begin
      // Lands on the clock edge where this rise is consumed.
      tick(2);
      rx_if.en = 1'b0;
      tick(half - 2);
    end else begin
      tick(half);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int half, input bit drop_last);
    for (int i = 7; i >= 0; i--) send_bit(v[i], half, drop_last && (i == 0));
  endtask

  task automatic check_got(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
    logic [7:0] e [3];
    e[0] = b0; e[1] = b1; e[2] = b2;
    chk("byte_count", got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) chk("byte_value", int'(got_q[i]), int'(e[i]));
    got_q.delete();
  endtask

  initial begin
    rx_if.en = 1'b0; rx_if.sclk = 1'b0; rx_if.sdata = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset_data", int'(rx_if.data), 0);
    chk("reset_valid", int'(rx_if.valid), 0);
    chk("reset_locked", int'(rx_if.locked), 0);
    chk("reset_lost", int'(rx_if.lost), 0);
    tick(2);
    rst = 1'b0;
    started = 1'b1;
    rx_if.en = 1'b1;
    tick(3);

    // Sync then three payload bytes at a 16-clock bit period.
    send_byte(8'hA5, 8, 1'b0);
    chk("locked_after_sync", int'(rx_if.locked), 1);
    send_byte(8'h01, 8, 1'b0);
    send_byte(8'h02, 8, 1'b0);
    send_byte(8'h03, 8, 1'b0);
    tick(4);
    check_got(3, 8'h01, 8'h02, 8'h03);

    // Re-hunt: a leading non-sync byte is ignored.
    rx_if.en = 1'b0;
    tick(3);
    rx_if.en = 1'b1;
    tick(2);
    send_byte(8'h3C, 4, 1'b0);
    send_byte(8'hA5, 4, 1'b0);
    send_byte(8'h7E, 4, 1'b0);
    tick(4);
    check_got(1, 8'h7E, 8'h00, 8'h00);

    // Bit clock stops high: lock is lost, then reacquired.
    tick(TIMEOUT + 10);
    chk("lost_count", lost_cnt, 1);
    chk("unlocked_after_loss", int'(rx_if.locked), 0);
    send_byte(8'hA5, 3, 1'b0);
    send_byte(8'h55, 3, 1'b0);
    tick(4);
    check_got(1, 8'h55, 8'h00, 8'h00);

    // Sync pattern as payload is forwarded without realignment.
    send_byte(8'hA5, 3, 1'b0);
    tick(4);
    check_got(1, 8'hA5, 8'h00, 8'h00);
    chk("locked_after_a5_payload", int'(rx_if.locked), 1);

    // Enable drop coincides with the 8th bit: no byte, no loss.
    send_byte(8'h3C, 4, 1'b1);
    tick(5);
    check_got(0, 8'h00, 8'h00, 8'h00);
    chk("unlocked_after_en_drop", int'(rx_if.locked), 0);
    chk("lost_count_en_drop", lost_cnt, 1);
    rx_if.en = 1'b1;
    tick(2);

    // Reset in the middle of a byte.
    send_byte(8'hA5, 3, 1'b0);
    for (int i = 7; i >= 4; i--) send_bit(1'(8'h5A >> i), 3, 1'b0);
    rst = 1'b1;
    #1;
    chk("midbyte_rst_data", int'(rx_if.data), 0);
    chk("midbyte_rst_valid", int'(rx_if.valid), 0);
    chk("midbyte_rst_locked", int'(rx_if.locked), 0);
    chk("midbyte_rst_lost", int'(rx_if.lost), 0);
    tick(3);
    rst = 1'b0;
    tick(2);
    for (int i = 3; i >= 0; i--) send_bit(1'(8'h5A >> i), 3, 1'b0);
    send_byte(8'h12, 3, 1'b0);
    tick(6);
    check_got(0, 8'h00, 8'h00, 8'h00);
    chk("unlocked_before_resync", int'(rx_if.locked), 0);
    send_byte(8'hA5, 3, 1'b0);
    send_byte(8'h99, 3, 1'b0);
    tick(4);
    check_got(1, 8'h99, 8'h00, 8'h00);

    // Random traffic: bytes, sync words, clock stalls and enable drops.
    for (int n = 0; n < 150; n++) begin
      int unsigned act;
      act = $urandom_range(0, 19);
      if (act < 3) begin
        send_byte(SYNC, int'($urandom_range(2, 6)), 1'b0);
      end else if (act == 3) begin
        tick(int'($urandom_range(20, TIMEOUT + 30)));
      end else if (act == 4) begin
        rx_if.en = 1'b0;
        tick(int'($urandom_range(1, 4)));
        rx_if.en = 1'b1;
      end else begin
        send_byte(8'($urandom), int'($urandom_range(2, 6)), 1'b0);
      end
    end
    tick(TIMEOUT + 10);
    got_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
